// File: rtl/sme_feeder_if.sv
// Upstream byte-stream interface for sme_feeder.
//   in_valid : source has a byte
//   in_ready : feeder accepts a byte this cycle
//   in_data  : byte value
//   in_kind  : 0 = string record, 1 = pattern record (meaningful on first byte only)
//   in_last  : final byte of the record
// master modport = byte source, slave modport = feeder.
interface sme_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_kind;
  logic       in_last;

  modport master (output in_valid, output in_data, output in_kind, output in_last,
                  input in_ready);
  modport slave  (input in_valid, input in_data, input in_kind, input in_last,
                  output in_ready);
endinterface

// File: rtl/sme_feeder.sv
// sme_feeder: buffers whole string/pattern records from a ready/valid byte stream and
// replays each one to the string-matching engine as a gap-free burst.
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   up                : upstream byte stream (slave side of sme_feeder_if)
//   chardata          : byte to SME, qualified by isstring / ispattern
//   isstring/ispattern: burst strobes, never both high
//   sme_valid         : SME result strobe, only honoured while waiting after a pattern
//   busy              : high whenever not collecting
//   err_ovf/err_nostr/err_tmo : single-cycle error pulses
module sme_feeder #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  sme_feeder_if.slave  up,
  output logic [7:0]   chardata,
  output logic         isstring,
  output logic         ispattern,
  input  logic         sme_valid,
  output logic         busy,
  output logic         err_ovf,
  output logic         err_nostr,
  output logic         err_tmo
);

  localparam int unsigned IdxW  = 6;
  localparam int unsigned AddrW = $clog2(STR_MAX);
  localparam int unsigned TmoW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StCollect, StPlay, StGap, StWaitRes} state_e;

  state_e          state_q, state_d;
  logic            kind_q, kind_d;
  logic [IdxW-1:0] len_q, len_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            ovf_q, ovf_d;
  logic            has_str_q, has_str_d;
  logic [TmoW-1:0] cnt_q, cnt_d;
  logic [7:0]      chardata_q, chardata_d;
  logic            isstring_q, isstring_d;
  logic            ispattern_q, ispattern_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_nostr_q, err_nostr_d;
  logic [7:0]      buf_q [STR_MAX];
  logic            buf_we;

  logic            xfer, first, kind_eff, room, tmo_hit;
  logic [IdxW-1:0] max_len;

  // Kind is only sampled on the first byte; later bytes use the latched value.
  assign xfer     = up.in_valid && (state_q == StCollect);
  assign first    = (len_q == '0);
  assign kind_eff = first ? up.in_kind : kind_q;
  assign max_len  = kind_eff ? IdxW'(PAT_MAX) : IdxW'(STR_MAX);
  assign room     = (len_q < max_len);
  assign tmo_hit  = (cnt_q == TmoW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StCollect;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (xfer && up.in_last && !(kind_eff && !has_str_q)) state_d = StPlay;
      StPlay:    if (idx_q >= len_q) state_d = StGap;
      StGap:     state_d = kind_q ? StWaitRes : StCollect;
      StWaitRes: if (sme_valid || tmo_hit) state_d = StCollect;
    endcase
  end

  // Output logic
  always_comb begin
    up.in_ready = (state_q == StCollect);
    busy        = (state_q != StCollect);
    // sme_valid wins over a coinciding timeout
    err_tmo     = (state_q == StWaitRes) && tmo_hit && !sme_valid;
  end

  // Datapath next-state
  always_comb begin
    kind_d      = kind_q;
    len_d       = len_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    has_str_d   = has_str_q;
    cnt_d       = cnt_q;
    chardata_d  = chardata_q;
    isstring_d  = isstring_q;
    ispattern_d = ispattern_q;
    err_ovf_d   = 1'b0;
    err_nostr_d = 1'b0;
    buf_we      = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (xfer) begin
          if (first) kind_d = up.in_kind;
          // Bytes past the limit are accepted but dropped; length saturates.
          if (room) begin
            buf_we = 1'b1;
            len_d  = len_q + IdxW'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (up.in_last) begin
            if (kind_eff && !has_str_q) begin
              err_nostr_d = 1'b1;
              len_d       = '0;
              ovf_d       = 1'b0;
            end else begin
              // Preload byte 0 so the burst starts the cycle after in_last.
              err_ovf_d   = ovf_q || !room;
              chardata_d  = first ? up.in_data : buf_q[0];
              isstring_d  = !kind_eff;
              ispattern_d = kind_eff;
              idx_d       = IdxW'(1);
            end
          end
        end
      end
      StPlay: begin
        if (idx_q < len_q) begin
          chardata_d = buf_q[idx_q[AddrW-1:0]];
          idx_d      = idx_q + IdxW'(1);
        end else begin
          isstring_d  = 1'b0;
          ispattern_d = 1'b0;
          len_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      StGap: begin
        if (!kind_q) has_str_d = 1'b1;
        cnt_d = '0;
      end
      StWaitRes: cnt_d = cnt_q + TmoW'(1);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q      <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      has_str_q   <= 1'b0;
      cnt_q       <= '0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_nostr_q <= 1'b0;
    end else begin
      kind_q      <= kind_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      has_str_q   <= has_str_d;
      cnt_q       <= cnt_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      err_ovf_q   <= err_ovf_d;
      err_nostr_q <= err_nostr_d;
    end
  end

  // Record storage needs no reset: len_q gates every read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[len_q[AddrW-1:0]] <= up.in_data;
  end

  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign err_ovf   = err_ovf_q;
  assign err_nostr = err_nostr_q;

endmodule

// File: doc/sme_feeder.md
Name: sme_feeder

Overview:
- Upstream framing stage for the string-matching engine (SME).
- Accepts a ready/valid byte stream of string and pattern records and buffers each record whole.
- Replays each record to the SME as one gap-free burst on chardata with isstring or ispattern held high.
- After each pattern burst, waits for the SME's valid before issuing the next record, so the SME never sees overlapping jobs.

Parameters:
STR_MAX, 32, max string record length in bytes (SME string buffer depth)
PAT_MAX, 8, max pattern record length in bytes (SME pattern buffer depth)
TIMEOUT, 64, cycles to wait for sme_valid before abandoning a pattern job

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream byte valid
in_ready  out  1  feeder can accept a byte
in_data  in  8  upstream byte
in_kind  in  1  record type: 0=string, 1=pattern; sampled on first byte of record only
in_last  in  1  final byte of current record
chardata  out  8  byte to SME
isstring  out  1  chardata is a string byte
ispattern  out  1  chardata is a pattern byte
sme_valid  in  1  SME result-valid strobe
busy  out  1  high in any state other than COLLECT
err_ovf  out  1  1-cycle pulse: record exceeded max length and was truncated
err_nostr  out  1  1-cycle pulse: pattern record arrived before any string; record discarded
err_tmo  out  1  1-cycle pulse: sme_valid not seen within TIMEOUT cycles

Behaviour:
- Reset values:
  - state=COLLECT; all outputs 0 except in_ready=1.
  - chardata=0; buffer length=0; has_str=0; all error pulses 0.
- Reset mid-burst drops isstring/ispattern immediately (asynchronous) and discards buffered data.
- States: COLLECT, PLAY, GAP, WAIT_RES.
- COLLECT:
  - in_ready=1. A byte transfers when in_valid&&in_ready.
  - First byte latches kind. Bytes are written at index 0,1,...
  - Bytes beyond STR_MAX (string) or PAT_MAX (pattern) are still accepted but dropped; an ovf flag is set.
  - On transfer of the in_last byte:
    - kind=pattern and has_str=0: err_nostr pulses the next cycle, the record is discarded, and the state stays COLLECT.
    - Otherwise go to PLAY; err_ovf pulses on the first PLAY cycle if the ovf flag is set.
  - A single-byte record (first byte with in_last) is legal.
- PLAY:
  - in_ready=0. chardata=buf[idx]; isstring=(kind==0), ispattern=(kind==1). The strobe is high for exactly len consecutive cycles.
  - Latency: in_last accepted at edge N, so the first played byte is visible in cycle N+1 and the last in cycle N+len.
  - Outputs are registered. chardata holds its last value after the burst, but the SME must only sample it qualified by the strobe.
  - After the last byte, go to GAP.
- GAP:
  - One cycle with isstring=ispattern=0.
  - String record: set has_str=1, go to COLLECT.
  - Pattern record: go to WAIT_RES with the timeout counter cleared.
- WAIT_RES:
  - in_ready=0. The counter increments each cycle.
  - sme_valid=1 returns to COLLECT on the next cycle.
  - Counter reaching TIMEOUT-1 without sme_valid: pulse err_tmo and return to COLLECT.
  - sme_valid takes priority when it coincides with timeout; err_tmo does not fire.
- sme_valid arriving in any other state is ignored.
- Consecutive string records are legal. The new string replaces the old; has_str stays 1.
- Index widths: idx/len are 6 bits (covers 32). Length saturates at the max; no wrap-around on overflow.
- isstring and ispattern are never high simultaneously.

Test Plan:
- String "abc" (3 bytes, in_last on 'c'), back-to-back valid -> isstring high exactly 3 cycles starting the cycle after 'c' accepted, chardata 61,62,63; then 1 idle cycle; in_ready=1 again.
- After the string, pattern "b" -> ispattern 1 cycle with chardata 62. in_ready stays 0 until sme_valid is driven 5 cycles later; in_ready=1 the cycle after sme_valid.
- Pattern "x" immediately after reset -> no ispattern, err_nostr pulses 1 cycle, in_ready never drops.
- 35-byte string -> isstring exactly 32 cycles with bytes 0..31, err_ovf pulse on the first PLAY cycle; the 10-byte pattern case is analogous (8 bytes played).
- Pattern played and sme_valid never asserted -> err_tmo pulses in WAIT_RES cycle 64, in_ready=1 the next cycle; sme_valid in the same cycle as the timeout -> no err_tmo.
- Reset asserted on the 2nd cycle of a 5-byte string burst -> isstring=0 immediately; has_str=0, so a following pattern gives err_nostr.
